// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop sync, debounce, edge and long-press pulses.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN             = 8,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 300_000_000,
  parameter int REPEAT_CYCLES     = 20_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_held,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 ||
      REPEAT_CYCLES < 1) begin : g_param_chk
    $error("btn_conditioner: timing parameters out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= btn_raw;
      s  <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t         state;
    state_t         state_nxt;
    logic [DBW-1:0] db_cnt;
    logic [DBW-1:0] db_nxt;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nxt;
    logic           level;
    logic           acc;
    logic           rise_nxt;
    logic           fall_nxt;
    logic           long_nxt;
    logic           rise_q;
    logic           fall_q;
    logic           long_q;

    assign level = (state != IDLE);

    always_comb begin
      db_nxt = '0;
      acc    = 1'b0;
      if (s[i] != level) begin
        if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1))
          acc = 1'b1;
        else
          db_nxt = db_cnt + DBW'(1);
      end
    end

    assign rise_nxt = acc & ~level;
    assign fall_nxt = acc & level;

    // A release accepted on the threshold cycle wins over the long press.
    assign long_nxt = level & ~fall_nxt &
                      (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));

    always_comb begin
      hold_nxt = '0;
      if (level) begin
        if (hold_cnt == HW'(LONG_PRESS_CYCLES))
          hold_nxt = hold_cnt;
        else
          hold_nxt = hold_cnt + HW'(1);
      end
    end

    always_comb begin
      state_nxt = state;
      unique case (state)
        IDLE:    if (rise_nxt) state_nxt = PRESSED;
        PRESSED: begin
          if (fall_nxt)      state_nxt = IDLE;
          else if (long_nxt) state_nxt = HELD;
        end
        HELD:    if (fall_nxt) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state    <= IDLE;
        db_cnt   <= '0;
        hold_cnt <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        state    <= state_nxt;
        db_cnt   <= db_nxt;
        hold_cnt <= hold_nxt;
        rise_q   <= rise_nxt;
        fall_q   <= fall_nxt;
        long_q   <= long_nxt;
      end
    end

    assign btn_level[i] = level;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;
    assign btn_long[i]  = long_q;
    assign btn_held[i]  = (state == HELD);

`ifdef BTN_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RW-1:0] rep_cnt;
    logic          rep_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (state == HELD && !fall_nxt) begin
          if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt <= '0;
            rep_q   <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end else begin
          rep_cnt <= '0;
        end
      end
    end

    assign btn_repeat[i] = rep_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: event-time reference model plus directed
// scenarios and randomized bouncing stimulus on four channels.
module tb_btn_conditioner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] level, rise, fall, lng, held, rep;

  btn_conditioner #(
    .N_BTN            (N),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (raw),
    .btn_level (level),
    .btn_rise  (rise),
    .btn_fall  (fall),
    .btn_long  (lng),
    .btn_held  (held),
    .btn_repeat(rep)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [N-1:0] smp[$];
  logic [N-1:0] e_level = '0, e_rise = '0, e_fall = '0;
  logic [N-1:0] e_long = '0, e_held = '0, e_rep = '0;
  int rise_e[N], long_e[N];
  int last_rise[N], last_fall[N], last_long[N];
  int n_rise[N], n_long[N], n_rep[N], first_rep[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      rise_e[i] = 0; long_e[i] = 0;
      last_rise[i] = -1; last_fall[i] = -1; last_long[i] = -1;
      n_rise[i] = 0; n_long[i] = 0; n_rep[i] = 0; first_rep[i] = -1;
    end
  end

  // Reference: level flips once the D most recent synchronized samples
  // (raw delayed by two edges) all disagree with it; the rest follows
  // from the time elapsed since the accepted press.
  always @(posedge clk or negedge rst) begin
    bit   all;
    int   idx;
    logic v;
    if (!rst) begin
      smp.delete();
      e_level = '0; e_rise = '0; e_fall = '0;
      e_long = '0; e_held = '0; e_rep = '0;
    end else begin
      cyc++;
      smp.push_back(raw);
      e_rise = '0; e_fall = '0; e_long = '0; e_rep = '0;
      for (int i = 0; i < N; i++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++) begin
          idx = smp.size() - 3 - j;
          v = (idx >= 0) ? smp[idx][i] : 1'b0;
          if (v == e_level[i]) all = 1'b0;
        end
        if (all) begin
          if (!e_level[i]) begin
            e_rise[i] = 1'b1;
            rise_e[i] = cyc;
            last_rise[i] = cyc;
            n_rise[i]++;
            n_rep[i] = 0;
            first_rep[i] = -1;
          end else begin
            e_fall[i] = 1'b1;
            e_held[i] = 1'b0;
            last_fall[i] = cyc;
          end
          e_level[i] = ~e_level[i];
        end
        if (e_level[i] && cyc - rise_e[i] == L) begin
          e_long[i] = 1'b1;
          e_held[i] = 1'b1;
          long_e[i] = cyc;
          last_long[i] = cyc;
          n_long[i]++;
        end
        if (REP && e_held[i] && e_level[i] && cyc > long_e[i] &&
            (cyc - long_e[i]) % R == 0) begin
          e_rep[i] = 1'b1;
          n_rep[i]++;
          if (first_rep[i] < 0) first_rep[i] = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({level, rise, fall, lng, held, rep} !==
        {e_level, e_rise, e_fall, e_long, e_held, e_rep}) begin
      errors++;
      $display("FAIL outputs cyc=%0d got lvl=%b rise=%b fall=%b long=%b held=%b rep=%b want lvl=%b rise=%b fall=%b long=%b held=%b rep=%b",
               cyc, level, rise, fall, lng, held, rep,
               e_level, e_rise, e_fall, e_long, e_held, e_rep);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int p, q, t, u, v0, base;
  int rem[N];

  initial begin
    tick(3);
    chk("reset_outputs", int'({level, rise, fall, lng, held, rep}), 0);
    rst = 1'b1;
    while (cyc < 10) tick(1);

    // clean short press on channel 0
    raw[0] = 1'b1;
    tick(10);
    raw[0] = 1'b0;
    tick(15);
    chk("clean_rise_cycle", last_rise[0], 16);
    chk("clean_fall_cycle", last_fall[0], 26);
    chk("clean_no_long", n_long[0], 0);

    // bounce on channel 1
    base = n_rise[1];
    for (int k = 0; k < 4; k++) begin
      raw[1] = (k % 2 == 0);
      tick(3);
    end
    t = cyc;
    raw[1] = 1'b1;
    tick(12);
    chk("bounce_single_rise", n_rise[1] - base, 1);
    chk("bounce_rise_cycle", last_rise[1], t + 6);
    raw[1] = 1'b0;
    tick(12);

    // long hold with repeats on channel 2
    p = cyc;
    raw[2] = 1'b1;
    tick(46);
    raw[2] = 1'b0;
    tick(12);
    chk("hold_rise_cycle", last_rise[2], p + 6);
    chk("hold_long_cycle", last_long[2], p + 26);
    chk("hold_fall_cycle", last_fall[2], p + 52);
    chk("hold_repeat_count", n_rep[2], REP ? 5 : 0);
    chk("hold_first_repeat", first_rep[2], REP ? p + 31 : -1);

    // simultaneous presses on channels 0 and 3
    q = cyc;
    raw[0] = 1'b1;
    raw[3] = 1'b1;
    tick(15);
    raw[0] = 1'b0;
    tick(25);
    raw[3] = 1'b0;
    tick(12);
    chk("dual_rise0", last_rise[0], q + 6);
    chk("dual_rise3", last_rise[3], q + 6);
    chk("dual_long3", last_long[3], q + 26);
    chk("dual_no_long0", n_long[0], 0);

    // reset in the middle of a hold
    u = cyc;
    raw[2] = 1'b1;
    tick(21);
    chk("pre_reset_level", int'(level[2]), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({level, rise, fall, lng, held, rep}), 0);
    tick(3);
    rst = 1'b1;
    v0 = cyc;
    tick(40);
    raw[2] = 1'b0;
    tick(12);
    chk("post_reset_rise", last_rise[2], v0 + 6);
    chk("post_reset_long", last_long[2], v0 + 26);
    chk("pre_reset_rise", u + 6 < v0 ? 1 : 0, 1);

    // random bouncing and holds on all channels
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 6);
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          raw[i] = ~raw[i];
          rem[i] = ($urandom % 4 == 0) ? $urandom_range(20, 40)
                                       : $urandom_range(1, 7);
        end
        rem[i]--;
      end
      if (k == 400) begin
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
      end
      tick(1);
    end
    raw = '0;
    tick(60);
    chk("quiet_level", int'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end input stage for the control path: conditions the raw board push-buttons (direction pad, power and gesture buttons) before they reach the on/off, gesture and time-adjust control logic. Each button gets a two-flop synchronizer and a debounce filter, then produces a clean level, single-cycle press/release pulses, and a long-press pulse with a held flag. The long-press output replaces the ad-hoc hold counters in downstream control blocks, for example the 3 s power-off hold.

## Interface
- N_BTN, 8, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); must be ≥ 2.
- LONG_PRESS_CYCLES, 300_000_000, cycles a level must stay high before the long-press pulse fires (3 s); must be ≥ 2.
- REPEAT_CYCLES, 20_000_000, auto-repeat period after a long press (used only with BTN_REPEAT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-low.
- btn_raw  in  N_BTN  raw asynchronous button inputs, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_rise  out  N_BTN  one-cycle pulse on accepted press.
- btn_fall  out  N_BTN  one-cycle pulse on accepted release.
- btn_long  out  N_BTN  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
- btn_held  out  N_BTN  high from the btn_long pulse until release is accepted.
- btn_repeat  out  N_BTN  auto-repeat pulses (see Configuration).

## Operation
- Channels are fully independent. Simultaneous activity on several channels is handled in parallel with no priority.
- Synchronizer: two flops per channel. The output is `s[i]`.
- Debounce:
  - The per-channel counter `db_cnt` has width $clog2(DEBOUNCE_CYCLES).
  - When `s[i] == btn_level[i]`: `db_cnt <= 0`.
  - Otherwise, `db_cnt` increments. When `db_cnt == DEBOUNCE_CYCLES-1` and still `s != level`: `btn_level <= s`, `db_cnt <= 0`.
  - Any bounce back to the current level before acceptance clears the counter.
- Edge pulses are registered and asserted in the same cycle that `btn_level` changes:
  - `btn_rise` on a 0→1 change.
  - `btn_fall` on a 1→0 change.
- Long press:
  - The per-channel counter `hold_cnt` has width $clog2(LONG_PRESS_CYCLES+1).
  - It is cleared while `btn_level == 0` and increments while `btn_level == 1`.
  - It saturates at LONG_PRESS_CYCLES.
  - `btn_long` pulses exactly once per press, on the cycle `hold_cnt` reaches LONG_PRESS_CYCLES.
  - `btn_held` is set in the same cycle as `btn_long` and cleared in the cycle `btn_fall` is asserted.
- Release before the threshold produces no `btn_long` and no `btn_held`.
- Per-channel state: IDLE (level 0) → PRESSED (rise) → HELD (long) → IDLE (fall). PRESSED → IDLE directly on fall.

## Timing
- Reset values:
  - All outputs 0.
  - Synchronizer flops, `db_cnt`, `hold_cnt` and repeat counters all 0.
- A button already pressed when reset is released yields `btn_rise` after the normal latency.
- Reset asserted mid-debounce or mid-hold discards all progress immediately (asynchronous). No pulse is emitted during or after reset for that in-flight event.
- Latency from the first clk edge sampling a new stable `btn_raw` to the `btn_level`/`btn_rise` change is 2 + DEBOUNCE_CYCLES cycles.
- If `btn_rise` is at cycle r:
  - `btn_long` is at r + LONG_PRESS_CYCLES.
  - The first `btn_repeat` is at r + LONG_PRESS_CYCLES + REPEAT_CYCLES, then every REPEAT_CYCLES.
- Pulses are exactly one cycle wide.
- `btn_rise` and `btn_fall` on the same channel are at least DEBOUNCE_CYCLES apart.

## Configuration
- BTN_REPEAT_EN defined:
  - While `btn_held` is 1, a per-channel counter pulses `btn_repeat` every REPEAT_CYCLES.
  - The counter is cleared on release or reset.
  - The first repeat occurs REPEAT_CYCLES after `btn_long`.
- BTN_REPEAT_EN undefined:
  - `btn_repeat` is tied to 0 and no repeat counters are synthesized.
  - The port list is unchanged.

## Test plan
Bench parameters: N_BTN=4, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5, BTN_REPEAT_EN defined.

- Clean press on btn_raw[0] at cycle 10, held 10 cycles -> `btn_level[0]` and a 1-cycle `btn_rise[0]` at cycle 16; release accepted with `btn_fall[0]` 6 cycles after the raw release; no `btn_long`.
- Bounce: btn_raw[1] toggles 1,0,1,0 for 3-cycle stretches, then steady 1 -> no `btn_rise` during the bounce; exactly one `btn_rise[1]` 6 cycles after the steady 1 starts.
- Hold btn_raw[2] for 40 cycles after rise at r -> `btn_long[2]` at r+20; `btn_held[2]` high from r+20 until `btn_fall`; `btn_repeat[2]` at r+25, r+30, r+35…
- Buttons 0 and 3 pressed in the same cycle -> `btn_rise` on both in the same cycle; each channel's long press is independent.
- Reset asserted while btn_raw[2] is held at hold_cnt=15 -> all outputs 0 immediately; after release of reset with the button still held, fresh `btn_rise` after 6 cycles and `btn_long` 20 cycles later.
- Build without BTN_REPEAT_EN, 40-cycle hold -> `btn_long` fires as above; `btn_repeat` stays 0 throughout.
